// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_scheduler
// Purpose  : Round-robin arbiter sharing the register file write port between
//            NUM_REQ writeback requesters, plus a per-register pending-write
//            scoreboard for read-after-write hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 5,
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DEPTH-1:0] req_index,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic                     write_enable,
    output logic [DEPTH-1:0]         write_index,
    output logic [WIDTH-1:0]         write_data,
    input  logic                     reserve_valid,
    input  logic [DEPTH-1:0]         reserve_index,
    output logic [(2**DEPTH)-1:0]    busy
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REG = 2 ** DEPTH;

    logic [PTR_W-1:0]   ptr_q,          ptr_d;
    logic               write_enable_q, write_enable_d;
    logic [DEPTH-1:0]   write_index_q,  write_index_d;
    logic [WIDTH-1:0]   write_data_q,   write_data_d;
    logic [NUM_REG-1:0] busy_q,         busy_d;

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [DEPTH-1:0]   sel_index;
    logic [WIDTH-1:0]   sel_data;

    // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
    always_comb begin
        logic [PTR_W:0] k;
        k         = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            k = {1'b0, ptr_q} + (PTR_W+1)'(j);
            if (k >= (PTR_W+1)'(NUM_REQ)) begin
                k = k - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[k[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = k[PTR_W-1:0];
            end
        end
        if (reset) begin
            grant_any = 1'b0;
        end
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_index = req_index[grant_idx*DEPTH +: DEPTH];
        sel_data  = req_data[grant_idx*WIDTH +: WIDTH];
    end

    always_comb begin
        ptr_d          = ptr_q;
        write_enable_d = 1'b0;
        write_index_d  = write_index_q;
        write_data_d   = write_data_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Register 0 is hard-wired zero: the grant is consumed but nothing is written.
            write_enable_d = (sel_index != '0);
            write_index_d  = sel_index;
            write_data_d   = sel_data;
        end
    end

    // Clear first, then set, so a new reservation beats a retiring write.
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_index_q] = 1'b0;
        end
        if (reserve_valid && (reserve_index != '0)) begin
            busy_d[reserve_index] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q          <= '0;
            write_enable_q <= 1'b0;
            write_index_q  <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            ptr_q          <= ptr_d;
            write_enable_q <= write_enable_d;
            write_index_q  <= write_index_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = grant_oh;
    assign write_enable = write_enable_q;
    assign write_index  = write_index_q;
    assign write_data   = write_data_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire
